// File: rtl/karatsuba_pkg.sv
// Shared types and defaults for the Karatsuba multiplier back-end stages.
package karatsuba_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int DEF_N_BITS    = 15;
    localparam int DEF_ACC_BITS  = 40;
    localparam int DEF_COUNT_MAX = 16;

    // Width needed to hold a product count from 0 up to and including count_max.
    function automatic int count_width(input int count_max);
        return $clog2(count_max + 1);
    endfunction

endpackage

// File: rtl/acc_add_sat.sv
// Accumulator adder with carry-out; clamps to all-ones when PROD_ACC_SAT_EN is defined,
// otherwise wraps modulo 2^ACC_BITS.
module acc_add_sat #(
    parameter int ACC_BITS = 40,
    parameter int IN_BITS  = 30
) (
    input  logic [ACC_BITS-1:0] acc,
    input  logic [IN_BITS-1:0]  addend,
    output logic [ACC_BITS-1:0] sum,
    output logic                carry
);

    logic [ACC_BITS:0] wide_sum;

    always_comb begin
        wide_sum = {1'b0, acc} + (ACC_BITS + 1)'(addend);
        carry    = wide_sum[ACC_BITS];
`ifdef PROD_ACC_SAT_EN
        sum = carry ? {ACC_BITS{1'b1}} : wide_sum[ACC_BITS-1:0];
`else
        sum = wide_sum[ACC_BITS-1:0];
`endif
    end

endmodule

// File: rtl/prod_accumulator.sv
// Sums bursts of multiplier products and presents each total on a held output handshake.
// Optional saturation of the accumulator is selected with the PROD_ACC_SAT_EN macro.
module prod_accumulator
    import karatsuba_pkg::*;
#(
    parameter int N_BITS    = DEF_N_BITS,
    parameter int ACC_BITS  = DEF_ACC_BITS,
    parameter int COUNT_MAX = DEF_COUNT_MAX,
    localparam int P_BITS   = 2 * N_BITS,
    localparam int CNT_BITS = count_width(COUNT_MAX)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [P_BITS-1:0]   in_prod,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ACC_BITS-1:0] out_sum,
    output logic [CNT_BITS-1:0] out_count,
    output logic                out_overflow,
    output logic [1:0]          dbg_state
);

    if (ACC_BITS < P_BITS) begin : g_bad_acc_bits
        $error("prod_accumulator: ACC_BITS must be >= 2*N_BITS");
    end
    if (COUNT_MAX < 1) begin : g_bad_count_max
        $error("prod_accumulator: COUNT_MAX must be >= 1");
    end

    // Handshakes: a beat moves on a rising edge where valid and ready are both high.
    // in_ready and out_valid are decodes of the registered state only, so neither
    // side ever sees a combinational path from the other side's valid/ready.

    state_t                state;
    state_t                state_next;
    logic [ACC_BITS-1:0]   acc;
    logic [CNT_BITS-1:0]   count;
    logic                  overflow;

    logic                  take_in;
    logic                  take_out;
    logic [CNT_BITS-1:0]   count_inc;
    logic [ACC_BITS-1:0]   add_sum;
    logic                  add_carry;

    assign take_in   = in_valid & in_ready;
    assign take_out  = out_valid & out_ready;
    assign count_inc = count + CNT_BITS'(1);

    acc_add_sat #(
        .ACC_BITS (ACC_BITS),
        .IN_BITS  (P_BITS)
    ) u_add (
        .acc    (acc),
        .addend (in_prod),
        .sum    (add_sum),
        .carry  (add_carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (take_in) begin
                    state_next = (in_last || COUNT_MAX == 1) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (take_in) begin
                    state_next = (in_last || count_inc == CNT_BITS'(COUNT_MAX)) ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                if (take_out) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state != HOLD);
        out_valid = (state == HOLD);
        dbg_state = state;
    end

    // The first product loads rather than adds, so a stale total can never leak into a new burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (take_in) begin
                        acc      <= ACC_BITS'(in_prod);
                        count    <= CNT_BITS'(1);
                        overflow <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (take_in) begin
                        acc      <= add_sum;
                        count    <= count_inc;
                        overflow <= overflow | add_carry;
                    end
                end
                HOLD: begin
                    if (take_out) begin
                        acc      <= '0;
                        count    <= '0;
                        overflow <= 1'b0;
                    end
                end
                default: begin
                    acc      <= '0;
                    count    <= '0;
                    overflow <= 1'b0;
                end
            endcase
        end
    end

    assign out_sum      = acc;
    assign out_count    = count;
    assign out_overflow = overflow;

endmodule
